multicycle_controlunit: RTL

Multi-cycle successor to the single-cycle RISC-V control unit. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and waits on a memory ready handshake. It supports addi, add, sub, lw, sw, beq, bne, lui and jal, and detects memory-stall timeouts with a watchdog. It sits between the shared instruction/data memory port and the datapath, which holds the PC, the instruction register, the register file and the ALU.

---
 rtl/mcu_pkg.sv | 47 ++++
 rtl/mcu_decoder.sv | 43 ++++
 rtl/multicycle_controlunit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V control unit.
package mcu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  localparam logic [6:0] OP_ALUI   = 7'h13;
  localparam logic [6:0] OP_ALUR   = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  localparam int unsigned ALU_ADD   = 0;
  localparam int unsigned ALU_SUB   = 1;
  localparam int unsigned ALU_PASSB = 2;

  localparam logic [1:0] IMM_I  = 2'd0;
  localparam logic [1:0] IMM_S  = 2'd1;
  localparam logic [1:0] IMM_B  = 2'd2;
  localparam logic [1:0] IMM_JU = 2'd3;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  typedef enum logic [3:0] {
    CL_ILLEGAL = 4'd0,
    CL_ADDI    = 4'd1,
    CL_ADD     = 4'd2,
    CL_SUB     = 4'd3,
    CL_LW      = 4'd4,
    CL_SW      = 4'd5,
    CL_BEQ     = 4'd6,
    CL_BNE     = 4'd7,
    CL_LUI     = 4'd8,
    CL_JAL     = 4'd9
  } iclass_e;

endpackage

// File: rtl/mcu_decoder.sv
// Combinational instruction classifier: opcode/funct3/funct7 to instruction class.
module mcu_decoder
  import mcu_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_e     iclass,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register and immediate fields do not affect classification.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  always_comb begin
    iclass = CL_ILLEGAL;
    case (opcode)
      OP_ALUI:   if (funct3 == 3'b000) iclass = CL_ADDI;
      OP_ALUR: begin
        if (funct3 == 3'b000 && funct7 == 7'h00)      iclass = CL_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'h20) iclass = CL_SUB;
      end
      OP_LOAD:   if (funct3 == 3'b010) iclass = CL_LW;
      OP_STORE:  if (funct3 == 3'b010) iclass = CL_SW;
      OP_BRANCH: begin
        if (funct3 == 3'b000)      iclass = CL_BEQ;
        else if (funct3 == 3'b001) iclass = CL_BNE;
      end
      OP_LUI:    iclass = CL_LUI;
      OP_JAL:    iclass = CL_JAL;
      default:   iclass = CL_ILLEGAL;
    endcase
  end

  assign illegal = (iclass == CL_ILLEGAL);

endmodule

// File: rtl/multicycle_controlunit.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait watchdog.
// Define MCU_TRAP_EN to fault on illegal instructions (otherwise they are NOPs).
module multicycle_controlunit
  import mcu_pkg::*;
#(
  parameter int unsigned ALUCTRL_W    = 3,
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 EQ,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic [ALUCTRL_W-1:0] ALUctrl,
  output logic                 ALUsrc,
  output logic [1:0]           ImmSrc,
  output logic                 PCsrc,
  output logic [1:0]           ResultSrc,
  output logic                 fault,
  output logic [2:0]           state_dbg
);

  localparam int unsigned CNT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  iclass_e          iclass;
  logic             illegal;
  logic             waiting;
  logic             timeout;

  mcu_decoder u_decoder (
    .instr   (instr),
    .iclass  (iclass),
    .illegal (illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The limit cycle is the MEM_WAIT_MAX-th consecutive cycle without mem_ready.
  assign waiting = (state_q == ST_FETCH || state_q == ST_MEM) && !mem_ready;
  assign timeout = waiting && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    ALUctrl   = ALUCTRL_W'(ALU_ADD);
    ALUsrc    = 1'b0;
    ImmSrc    = IMM_I;
    PCsrc     = 1'b0;
    ResultSrc = RES_ALU;
    fault     = 1'b0;
    state_dbg = state_q;

    // Operand selection is held from EXEC through WB so the ALU result stays valid.
    if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
      case (iclass)
        CL_ADDI, CL_LW: ALUsrc = 1'b1;
        CL_SUB:         ALUctrl = ALUCTRL_W'(ALU_SUB);
        CL_SW: begin
          ALUsrc = 1'b1;
          ImmSrc = IMM_S;
        end
        CL_BEQ, CL_BNE: begin
          ALUctrl = ALUCTRL_W'(ALU_SUB);
          ImmSrc  = IMM_B;
        end
        CL_LUI: begin
          ALUctrl = ALUCTRL_W'(ALU_PASSB);
          ALUsrc  = 1'b1;
          ImmSrc  = IMM_JU;
        end
        CL_JAL:  ImmSrc = IMM_JU;
        default: ;
      endcase
    end

    case (state_q)
      ST_FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (illegal) begin
`ifdef MCU_TRAP_EN
          state_d = ST_FAULT;
`else
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (iclass)
          CL_LW, CL_SW: state_d = ST_MEM;
          CL_BEQ: begin
            PCsrc   = 1'b1;
            PCWrite = EQ;
            state_d = ST_FETCH;
          end
          CL_BNE: begin
            PCsrc   = 1'b1;
            PCWrite = !EQ;
            state_d = ST_FETCH;
          end
          CL_JAL: begin
            PCsrc   = 1'b1;
            PCWrite = 1'b1;
            state_d = ST_WB;
          end
          CL_ADDI, CL_ADD, CL_SUB, CL_LUI: state_d = ST_WB;
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        MemRead  = (iclass == CL_LW);
        MemWrite = (iclass == CL_SW);
        if (mem_ready)    state_d = (iclass == CL_LW) ? ST_WB : ST_FETCH;
        else if (timeout) state_d = ST_FAULT;
      end
      ST_WB: begin
        RegWrite = 1'b1;
        if (iclass == CL_LW)       ResultSrc = RES_MEM;
        else if (iclass == CL_JAL) ResultSrc = RES_PC4;
        state_d = ST_FETCH;
      end
      ST_FAULT: fault = 1'b1;
      default:  state_d = ST_FETCH;
    endcase

    cnt_d = (state_d == state_q && waiting) ? cnt_q + 1'b1 : '0;

    // While reset is held, present the reset values immediately.
    if (rst) begin
      PCWrite   = 1'b0;
      IRWrite   = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      ALUctrl   = '0;
      ALUsrc    = 1'b0;
      ImmSrc    = '0;
      PCsrc     = 1'b0;
      ResultSrc = '0;
      fault     = 1'b0;
      state_dbg = ST_FETCH;
    end
  end

endmodule
